hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 25 ++
 rtl/hazard_unit_if.sv | 48 ++++
 rtl/hazard_unit_fwd_sel.sv | 25 ++
 rtl/hazard_unit.sv | 121 ++++++++++++
 tb/tb_hazard_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit: widths, forwarding-select and FSM encodings.
package hazard_unit_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned FWD_W   = 2;
    localparam int unsigned STALL_W = 16;
    localparam int unsigned WAIT_W  = 8;

    typedef enum logic [FWD_W-1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } hz_state_e;

    // r0 is hardwired to zero, so it never carries a dependency
    function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a == b) && (a != '0);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle; slave is the hazard unit, master the pipeline.
interface hazard_unit_if;
    import hazard_unit_pkg::*;

    logic [REG_W-1:0]   id_RegisterRs;
    logic [REG_W-1:0]   id_RegisterRt;
    logic [REG_W-1:0]   exe_RegisterRs;
    logic [REG_W-1:0]   exe_RegisterRt;
    logic [REG_W-1:0]   exe_WriteReg;
    logic               exe_MemRead;
    logic               exe_RegWrite;
    logic               exe_BranchTaken;
    logic [REG_W-1:0]   mem_WriteReg;
    logic               mem_RegWrite;
    logic               mem_MemRead;
    logic               mem_MemWrite;
    logic [REG_W-1:0]   wb_WriteReg;
    logic               wb_RegWrite;
    logic               dmem_ready;

    logic               stall_front;
    logic               idex_bubble;
    logic               flush_ifid;
    logic               freeze_all;
    logic               dmem_req;
    fwd_e               fwd_a;
    fwd_e               fwd_b;
    hz_state_e          hz_state;
    logic [STALL_W-1:0] stall_cnt;
    logic               err_timeout;

    modport master (
        output id_RegisterRs, id_RegisterRt, exe_RegisterRs, exe_RegisterRt, exe_WriteReg,
               exe_MemRead, exe_RegWrite, exe_BranchTaken, mem_WriteReg, mem_RegWrite,
               mem_MemRead, mem_MemWrite, wb_WriteReg, wb_RegWrite, dmem_ready,
        input  stall_front, idex_bubble, flush_ifid, freeze_all, dmem_req,
               fwd_a, fwd_b, hz_state, stall_cnt, err_timeout
    );

    modport slave (
        input  id_RegisterRs, id_RegisterRt, exe_RegisterRs, exe_RegisterRt, exe_WriteReg,
               exe_MemRead, exe_RegWrite, exe_BranchTaken, mem_WriteReg, mem_RegWrite,
               mem_MemRead, mem_MemWrite, wb_WriteReg, wb_RegWrite, dmem_ready,
        output stall_front, idex_bubble, flush_ifid, freeze_all, dmem_req,
               fwd_a, fwd_b, hz_state, stall_cnt, err_timeout
    );

endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// One ALU operand bypass select; MEM result wins over WB when both match.
module hazard_unit_fwd_sel
    import hazard_unit_pkg::*;
(
    input  logic             en,
    input  logic [REG_W-1:0] src_reg,
    input  logic [REG_W-1:0] mem_write_reg,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_write_reg,
    input  logic             wb_reg_write,
    output fwd_e             sel_c
);

    always_comb begin
        sel_c = FWD_RF;
        if (en) begin
            if (mem_reg_write && reg_match(mem_write_reg, src_reg)) begin
                sel_c = FWD_MEM;
            end else if (wb_reg_write && reg_match(wb_write_reg, src_reg)) begin
                sel_c = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: bypass selects, load-use/branch control, data-memory wait FSM.
// HAZARD_FORWARD_EN defined enables bypassing; undefined stalls on every EXE/MEM dependency.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    hz_state_e          state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [STALL_W-1:0] stall_cnt_q;
    logic               err_q;

    logic data_hazard_c;
    logic dmem_req_c;
    logic freeze_c;
    logic stall_front_c;
    logic idex_bubble_c;
    logic flush_ifid_c;
    fwd_e fwd_a_c;
    fwd_e fwd_b_c;

`ifdef HAZARD_FORWARD_EN
    localparam logic FWD_ON = 1'b1;

    // Only a load in EXE cannot be bypassed in time
    assign data_hazard_c = hz.exe_MemRead &&
                           (reg_match(hz.exe_WriteReg, hz.id_RegisterRs) ||
                            reg_match(hz.exe_WriteReg, hz.id_RegisterRt));
`else
    localparam logic FWD_ON = 1'b0;

    // No bypass: wait out any pending EXE/MEM write; WB is covered by the write-first register file
    assign data_hazard_c = (hz.exe_RegWrite &&
                            (reg_match(hz.exe_WriteReg, hz.id_RegisterRs) ||
                             reg_match(hz.exe_WriteReg, hz.id_RegisterRt))) ||
                           (hz.mem_RegWrite &&
                            (reg_match(hz.mem_WriteReg, hz.id_RegisterRs) ||
                             reg_match(hz.mem_WriteReg, hz.id_RegisterRt)));
`endif

    hazard_unit_fwd_sel u_fwd_a (
        .en            (FWD_ON),
        .src_reg       (hz.exe_RegisterRs),
        .mem_write_reg (hz.mem_WriteReg),
        .mem_reg_write (hz.mem_RegWrite),
        .wb_write_reg  (hz.wb_WriteReg),
        .wb_reg_write  (hz.wb_RegWrite),
        .sel_c         (fwd_a_c)
    );

    hazard_unit_fwd_sel u_fwd_b (
        .en            (FWD_ON),
        .src_reg       (hz.exe_RegisterRt),
        .mem_write_reg (hz.mem_WriteReg),
        .mem_reg_write (hz.mem_RegWrite),
        .wb_write_reg  (hz.wb_WriteReg),
        .wb_reg_write  (hz.wb_RegWrite),
        .sel_c         (fwd_b_c)
    );

    // Control priority: memory freeze, then taken branch, then data hazard
    always_comb begin
        dmem_req_c    = (state == MEMWAIT) || hz.mem_MemRead || hz.mem_MemWrite;
        freeze_c      = dmem_req_c && !hz.dmem_ready;
        stall_front_c = 1'b0;
        idex_bubble_c = 1'b0;
        flush_ifid_c  = 1'b0;
        if (freeze_c) begin
            stall_front_c = 1'b1;
        end else if (hz.exe_BranchTaken) begin
            flush_ifid_c  = 1'b1;
            idex_bubble_c = 1'b1;
        end else if (data_hazard_c) begin
            stall_front_c = 1'b1;
            idex_bubble_c = 1'b1;
        end
    end

    // Wait FSM, timeout watchdog and stall statistics
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                RUN:     if (freeze_c)      state <= MEMWAIT;
                MEMWAIT: if (hz.dmem_ready) state <= RUN;
            endcase

            if ((state == MEMWAIT) && !hz.dmem_ready) begin
                if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
                if (wait_cnt == WAIT_MAX - WAIT_W'(1)) err_q <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (stall_front_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + STALL_W'(1);
            end
        end
    end

    assign hz.stall_front = stall_front_c;
    assign hz.idex_bubble = idex_bubble_c;
    assign hz.flush_ifid  = flush_ifid_c;
    assign hz.freeze_all  = freeze_c;
    assign hz.dmem_req    = dmem_req_c;
    assign hz.fwd_a       = fwd_a_c;
    assign hz.fwd_b       = fwd_b_c;
    assign hz.hz_state    = state;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.err_timeout = err_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit; expectations adapt to whether HAZARD_FORWARD_EN is defined.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    hazard_unit_if hif ();

    hazard_unit dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sf;
        logic        bub;
        logic        fl;
        logic        frz;
        logic        req;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        st;
        logic [15:0] sc;
        logic        err;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    logic [15:0] m_sc  = '0;
    logic        m_st  = 1'b0;
    logic        m_err = 1'b0;

    function automatic obs_t sample();
        obs_t o;
        o.sf  = hif.stall_front;
        o.bub = hif.idex_bubble;
        o.fl  = hif.flush_ifid;
        o.frz = hif.freeze_all;
        o.req = hif.dmem_req;
        o.fa  = hif.fwd_a;
        o.fb  = hif.fwd_b;
        o.st  = hif.hz_state;
        o.sc  = hif.stall_cnt;
        o.err = hif.err_timeout;
        return o;
    endfunction

    // Queue the expected outputs for the coming cycle; stall counter model advances on stalls
    task automatic push_exp(input string n, input logic sf, input logic bub, input logic fl,
                            input logic frz, input logic req, input logic [1:0] fa,
                            input logic [1:0] fb);
        obs_t e;
        e = '{sf: sf, bub: bub, fl: fl, frz: frz, req: req, fa: fa, fb: fb,
              st: m_st, sc: m_sc, err: m_err};
        exp_q.push_back(e);
        name_q.push_back(n);
        if (sf && (m_sc != 16'hFFFF)) m_sc = m_sc + 16'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hif.id_RegisterRs   = '0;
        hif.id_RegisterRt   = '0;
        hif.exe_RegisterRs  = '0;
        hif.exe_RegisterRt  = '0;
        hif.exe_WriteReg    = '0;
        hif.exe_MemRead     = 1'b0;
        hif.exe_RegWrite    = 1'b0;
        hif.exe_BranchTaken = 1'b0;
        hif.mem_WriteReg    = '0;
        hif.mem_RegWrite    = 1'b0;
        hif.mem_MemRead     = 1'b0;
        hif.mem_MemWrite    = 1'b0;
        hif.wb_WriteReg     = '0;
        hif.wb_RegWrite     = 1'b0;
        hif.dmem_ready      = 1'b1;
    endtask

    task automatic test_reset();
        obs_t e, o;
        string n;
        rst = 1'b0;
        idle();
        tick();
        m_st = 1'b0; m_sc = '0; m_err = 1'b0;

        push_exp("reset_idle", 0, 0, 0, 0, 0, 2'b00, 2'b00);
        @(negedge clk);
        e = exp_q.pop_front(); n = name_q.pop_front(); o = sample(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL %s: observed %h expected %h", n, o, e); end
        tick();

        // Combinational controls still follow inputs during reset, but the counter stays cleared
        hif.exe_MemRead = 1'b1; hif.exe_RegWrite = 1'b1; hif.exe_WriteReg = 5'd8;
        hif.id_RegisterRt = 5'd8;
        push_exp("reset_comb", 1, 1, 0, 0, 0, 2'b00, 2'b00);
        @(negedge clk);
        e = exp_q.pop_front(); n = name_q.pop_front(); o = sample(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL %s: observed %h expected %h", n, o, e); end
        tick();
        m_sc = '0;

        rst = 1'b1;
        idle();
        push_exp("post_reset", 0, 0, 0, 0, 0, 2'b00, 2'b00);
        @(negedge clk);
        e = exp_q.pop_front(); n = name_q.pop_front(); o = sample(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL %s: observed %h expected %h", n, o, e); end
        tick();
    endtask

    typedef struct {
        string      n;
        logic [4:0] mwr;
        logic       mw;
        logic [4:0] wwr;
        logic       ww;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] fa;
        logic [1:0] fb;
    } fv_t;

    task automatic test_forward();
        obs_t  e, o;
        string n;
        fv_t   fv [6];
        fv[0] = '{"fwd_mem_over_wb", 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 5'd7, 2'b10, 2'b00};
        fv[1] = '{"fwd_r0",          5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00};
        fv[2] = '{"fwd_wb_b",        5'd4, 1'b0, 5'd9, 1'b1, 5'd3, 5'd9, 2'b00, 2'b01};
        fv[3] = '{"fwd_mem_both",    5'd4, 1'b1, 5'd4, 1'b1, 5'd4, 5'd4, 2'b10, 2'b10};
        fv[4] = '{"fwd_nowrite",     5'd4, 1'b0, 5'd4, 1'b0, 5'd4, 5'd4, 2'b00, 2'b00};
        fv[5] = '{"fwd_split",       5'd6, 1'b1, 5'd2, 1'b1, 5'd2, 5'd6, 2'b01, 2'b10};
        idle();
        hif.id_RegisterRs = 5'd30;
        hif.id_RegisterRt = 5'd31;
        for (int i = 0; i < 6; i++) begin
            hif.mem_WriteReg   = fv[i].mwr;
            hif.mem_RegWrite   = fv[i].mw;
            hif.wb_WriteReg    = fv[i].wwr;
            hif.wb_RegWrite    = fv[i].ww;
            hif.exe_RegisterRs = fv[i].rs;
            hif.exe_RegisterRt = fv[i].rt;
            push_exp(fv[i].n, 0, 0, 0, 0, 0, FWD ? fv[i].fa : 2'b00, FWD ? fv[i].fb : 2'b00);
            @(negedge clk);
            e = exp_q.pop_front(); n = name_q.pop_front(); o = sample(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL %s: observed %h expected %h", n, o, e); end
            tick();
        end
    endtask

    typedef struct {
        string      n;
        logic       emr;
        logic       erw;
        logic [4:0] ewr;
        logic       mrw;
        logic [4:0] mwr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       sf_fwd;
        logic       sf_def;
    } lv_t;

    task automatic test_load_use();
        obs_t  e, o;
        string n;
        lv_t   lv [7];
        logic  sf;
        lv[0] = '{"lu_rt",    1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  5'd1,  5'd8,  1'b1, 1'b1};
        lv[1] = '{"lu_gone",  1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  5'd1,  5'd8,  1'b0, 1'b0};
        lv[2] = '{"lu_rs",    1'b1, 1'b1, 5'd12, 1'b0, 5'd0,  5'd12, 5'd3,  1'b1, 1'b1};
        lv[3] = '{"lu_r0",    1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0};
        lv[4] = '{"alu_dep",  1'b0, 1'b1, 5'd9,  1'b0, 5'd0,  5'd9,  5'd2,  1'b0, 1'b1};
        lv[5] = '{"mem_dep",  1'b0, 1'b0, 5'd0,  1'b1, 5'd11, 5'd4,  5'd11, 1'b0, 1'b1};
        lv[6] = '{"no_dep",   1'b1, 1'b1, 5'd8,  1'b1, 5'd11, 5'd2,  5'd3,  1'b0, 1'b0};
        idle();
        for (int i = 0; i < 7; i++) begin
            hif.exe_MemRead   = lv[i].emr;
            hif.exe_RegWrite  = lv[i].erw;
            hif.exe_WriteReg  = lv[i].ewr;
            hif.mem_RegWrite  = lv[i].mrw;
            hif.mem_WriteReg  = lv[i].mwr;
            hif.id_RegisterRs = lv[i].rs;
            hif.id_RegisterRt = lv[i].rt;
            sf = FWD ? lv[i].sf_fwd : lv[i].sf_def;
            push_exp(lv[i].n, sf, sf, 0, 0, 0, 2'b00, 2'b00);
            @(negedge clk);
            e = exp_q.pop_front(); n = name_q.pop_front(); o = sample(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL %s: observed %h expected %h", n, o, e); end
            tick();
        end
    endtask

    task automatic test_branch();
        obs_t e, o;
        string n;
        idle();
        for (int i = 0; i < 3; i++) begin
            idle();
            if (i == 0) begin
                hif.exe_BranchTaken = 1'b1;
                hif.exe_MemRead = 1'b1; hif.exe_RegWrite = 1'b1; hif.exe_WriteReg = 5'd8;
                hif.id_RegisterRt = 5'd8;
                push_exp("br_load_use", 0, 1, 1, 0, 0, 2'b00, 2'b00);
            end else if (i == 1) begin
                hif.exe_BranchTaken = 1'b1;
                push_exp("br_only", 0, 1, 1, 0, 0, 2'b00, 2'b00);
            end else begin
                push_exp("br_clear", 0, 0, 0, 0, 0, 2'b00, 2'b00);
            end
            @(negedge clk);
            e = exp_q.pop_front(); n = name_q.pop_front(); o = sample(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL %s: observed %h expected %h", n, o, e); end
            tick();
        end
    endtask

    task automatic test_memwait();
        obs_t e, o;
        string n;
        for (int c = 1; c <= 7; c++) begin
            idle();
            case (c)
                1: begin
                    hif.mem_MemRead = 1'b1; hif.dmem_ready = 1'b0;
                    push_exp("mw_enter", 1, 0, 0, 1, 1, 2'b00, 2'b00);
                end
                2: begin
                    hif.mem_MemRead = 1'b1; hif.dmem_ready = 1'b0;
                    hif.exe_BranchTaken = 1'b1;
                    hif.exe_MemRead = 1'b1; hif.exe_RegWrite = 1'b1; hif.exe_WriteReg = 5'd8;
                    hif.id_RegisterRt = 5'd8;
                    push_exp("mw_freeze_prio", 1, 0, 0, 1, 1, 2'b00, 2'b00);
                end
                3: begin
                    hif.dmem_ready = 1'b0;
                    push_exp("mw_hold_req", 1, 0, 0, 1, 1, 2'b00, 2'b00);
                end
                4: begin
                    hif.mem_MemRead = 1'b1;
                    push_exp("mw_ready", 0, 0, 0, 0, 1, 2'b00, 2'b00);
                end
                5: push_exp("mw_idle", 0, 0, 0, 0, 0, 2'b00, 2'b00);
                6: begin
                    hif.mem_MemWrite = 1'b1;
                    push_exp("mw_write_ready", 0, 0, 0, 0, 1, 2'b00, 2'b00);
                end
                default: push_exp("mw_run", 0, 0, 0, 0, 0, 2'b00, 2'b00);
            endcase
            @(negedge clk);
            e = exp_q.pop_front(); n = name_q.pop_front(); o = sample(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL %s: observed %h expected %h", n, o, e); end
            tick();
            if (c == 1) m_st = 1'b1;
            if (c == 4) m_st = 1'b0;
        end
    endtask

    task automatic test_timeout();
        obs_t e, o;
        string n;
        idle();
        hif.mem_MemRead = 1'b1;
        hif.dmem_ready  = 1'b0;
        // Cycle 1 is the RUN cycle that enters MEMWAIT; MEMWAIT cycle k is loop cycle k+1
        for (int c = 1; c <= 300; c++) begin
            if (c == 257) m_err = 1'b1;
            push_exp("to_wait", 1, 0, 0, 1, 1, 2'b00, 2'b00);
            @(negedge clk);
            e = exp_q.pop_front(); n = name_q.pop_front(); o = sample(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL %s cycle %0d: observed %h expected %h", n, c, o, e);
            end
            tick();
            if (c == 1) m_st = 1'b1;
        end

        for (int c = 0; c < 5; c++) begin
            idle();
            case (c)
                0: begin
                    hif.mem_MemRead = 1'b1;
                    push_exp("to_release", 0, 0, 0, 0, 1, 2'b00, 2'b00);
                end
                1: push_exp("to_sticky", 0, 0, 0, 0, 0, 2'b00, 2'b00);
                2: begin
                    hif.mem_MemRead = 1'b1; hif.dmem_ready = 1'b0;
                    push_exp("to_rewait", 1, 0, 0, 1, 1, 2'b00, 2'b00);
                end
                3: begin
                    rst = 1'b0; hif.dmem_ready = 1'b0;
                    push_exp("to_rst_in_wait", 1, 0, 0, 1, 1, 2'b00, 2'b00);
                end
                default: begin
                    rst = 1'b1; hif.dmem_ready = 1'b0;
                    push_exp("to_after_rst", 0, 0, 0, 0, 0, 2'b00, 2'b00);
                end
            endcase
            @(negedge clk);
            e = exp_q.pop_front(); n = name_q.pop_front(); o = sample(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL %s: observed %h expected %h", n, o, e); end
            tick();
            if (c == 0) m_st = 1'b0;
            if (c == 2) m_st = 1'b1;
            if (c == 3) begin m_st = 1'b0; m_sc = '0; m_err = 1'b0; end
        end
        rst = 1'b1;
        idle();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_memwait();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
